// File: rtl/bool_lut_pipe_if.sv
// bool_lut_pipe_if: valid/ready stream bundle for bool_lut_pipe.
//
// Handshake: a beat moves across a channel on a rising clk edge where
// valid and ready are both 1. The producer holds data while valid is
// waiting; ready may depend combinationally on the far side's ready.
//
// Signals
//   in_valid / in_ready       input channel handshake
//   in_a, in_b [WIDTH]        per-lane operands
//   out_valid / out_ready     output channel handshake
//   out_data [WIDTH]          per-lane function result
//   out_pop [$clog2(WIDTH+1)] number of 1s in out_data
//
// Modports
//   master  producer/consumer side (drives inputs, takes outputs)
//   slave   pipeline side
interface bool_lut_pipe_if #(
  parameter int WIDTH = 8
);
  localparam int PW = $clog2(WIDTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [PW-1:0]    out_pop;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_data, out_pop
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_data, out_pop
  );
endinterface

// File: rtl/bool_lut_pipe.sv
// bool_lut_pipe: WIDTH-lane programmable 2-input boolean function with a
// two-stage elastic pipeline and saturating observability counters.
//
// Each lane computes out_data[i] = tt[{a[i], b[i]}], where tt is the truth
// table snapshotted when the beat was accepted on the input channel.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   cfg_we     load cfg_tt into tt_cur at the edge
//   cfg_tt     new truth table, bit index = {a,b}
//   cnt_clr    synchronous clear of beat_cnt / rise_cnt (wins over counting)
//   bus        stream interface (slave modport), see bool_lut_pipe_if
//   tt_cur     current truth-table register
//   beat_cnt   delivered output beats, saturating
//   rise_cnt   delivered beats where out_data[0] rose vs previous delivered beat
module bool_lut_pipe #(
  parameter int          WIDTH    = 8,
  parameter int          CNT_W    = 16,
  parameter logic [3:0]  TT_RESET = 4'b0010
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_tt,
  input  logic              cnt_clr,
  bool_lut_pipe_if.slave    bus,
  output logic [3:0]        tt_cur,
  output logic [CNT_W-1:0]  beat_cnt,
  output logic [CNT_W-1:0]  rise_cnt
);
  localparam int PW = $clog2(WIDTH + 1);

  // Stage 1: raw operands plus the table in force when the beat was taken.
  logic             s1_v;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [3:0]       s1_tt;

  // Stage 2: evaluated result presented on the output channel.
  logic             s2_v;
  logic [WIDTH-1:0] s2_data;
  logic [PW-1:0]    s2_pop;

  logic             prev_bit0;

  logic             s2_load;
  logic             in_acc;
  logic             out_hs;
  logic [WIDTH-1:0] lut_res;
  logic [PW-1:0]    lut_pop;

  // S2 takes S1 when S2 is empty or is being drained this cycle.
  assign s2_load = s1_v & (~s2_v | bus.out_ready);
  // S1 can take a new beat when empty or when its beat moves to S2.
  // Held low during reset so nothing is accepted by a discarded pipeline.
  assign bus.in_ready  = rst_n & (~s1_v | s2_load);
  assign in_acc        = bus.in_valid & bus.in_ready;
  assign out_hs        = s2_v & bus.out_ready;

  assign bus.out_valid = s2_v;
  assign bus.out_data  = s2_data;
  assign bus.out_pop   = s2_pop;

  // Per-lane lookup and popcount of the S1 contents.
  always_comb begin
    lut_res = '0;
    lut_pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      lut_res[i] = s1_tt[{s1_a[i], s1_b[i]}];
      lut_pop    = lut_pop + PW'(lut_res[i]);
    end
  end

  // Truth-table register. A beat accepted in the same cycle as cfg_we
  // captures the old value because s1_tt samples tt_cur before this update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tt_cur <= TT_RESET;
    end else if (cfg_we) begin
      tt_cur <= cfg_tt;
    end
  end

  // Stage 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v  <= 1'b0;
      s1_a  <= '0;
      s1_b  <= '0;
      s1_tt <= TT_RESET;
    end else begin
      if (bus.in_ready) begin
        s1_v <= bus.in_valid;
      end
      if (in_acc) begin
        s1_a  <= bus.in_a;
        s1_b  <= bus.in_b;
        s1_tt <= tt_cur;
      end
    end
  end

  // Stage 2. Data only changes on a load, so a stalled beat holds stable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_v    <= 1'b0;
      s2_data <= '0;
      s2_pop  <= '0;
    end else if (s2_load) begin
      s2_v    <= 1'b1;
      s2_data <= lut_res;
      s2_pop  <= lut_pop;
    end else if (out_hs) begin
      s2_v    <= 1'b0;
    end
  end

  // Event counters. cnt_clr beats the increment of a coinciding beat,
  // while prev_bit0 still tracks every delivered beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_cnt  <= '0;
      rise_cnt  <= '0;
      prev_bit0 <= 1'b0;
    end else begin
      if (out_hs) begin
        prev_bit0 <= s2_data[0];
      end
      if (cnt_clr) begin
        beat_cnt <= '0;
        rise_cnt <= '0;
      end else if (out_hs) begin
        if (beat_cnt != '1) begin
          beat_cnt <= beat_cnt + CNT_W'(1);
        end
        if (s2_data[0] && !prev_bit0 && (rise_cnt != '1)) begin
          rise_cnt <= rise_cnt + CNT_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_bool_lut_pipe.sv
module tb_bool_lut_pipe;
  localparam logic [3:0] TT_RST = 4'b0010;

  logic        clk;
  logic        rst_n;
  logic        cfg_we;
  logic [3:0]  cfg_tt;
  logic        cnt_clr;
  logic [3:0]  tt_cur;
  logic [15:0] beat_cnt;
  logic [15:0] rise_cnt;

  // Second instance with narrow counters for the saturation scenario.
  logic [3:0]  tt_cur_s;
  logic [2:0]  beat_cnt_s;
  logic [2:0]  rise_cnt_s;

  bool_lut_pipe_if #(.WIDTH(8)) bus ();
  bool_lut_pipe_if #(.WIDTH(8)) bus_s ();

  bool_lut_pipe #(.WIDTH(8), .CNT_W(16), .TT_RESET(TT_RST)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_tt(cfg_tt),
    .cnt_clr(cnt_clr), .bus(bus), .tt_cur(tt_cur),
    .beat_cnt(beat_cnt), .rise_cnt(rise_cnt)
  );

  bool_lut_pipe #(.WIDTH(8), .CNT_W(3), .TT_RESET(TT_RST)) dut_s (
    .clk(clk), .rst_n(rst_n), .cfg_we(1'b0), .cfg_tt(4'b0000),
    .cnt_clr(1'b0), .bus(bus_s), .tt_cur(tt_cur_s),
    .beat_cnt(beat_cnt_s), .rise_cnt(rise_cnt_s)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping / model state ----------------
  int          total;
  int          bad;
  logic [7:0]  exp_q[$];
  logic [3:0]  m_tt;
  logic [15:0] m_beat;
  logic [15:0] m_rise;
  logic        m_prev;

  // Result of a lane function written as a sum of minterms selected by tt.
  function automatic logic [7:0] ref_lut(input logic [3:0] tt,
                                         input logic [7:0] a,
                                         input logic [7:0] b);
    logic [7:0] r;
    r = 8'h00;
    if (tt[0]) r = r | (~a & ~b);
    if (tt[1]) r = r | (~a &  b);
    if (tt[2]) r = r | ( a & ~b);
    if (tt[3]) r = r | ( a &  b);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: runs every falling edge, checks registers against the model,
  // then advances the model using the inputs that the next rising edge sees.
  task automatic monitor();
    logic [7:0] e;
    logic       hv;
    logic [7:0] hd;
    logic [3:0] hp;
    hv = 1'b0;
    hd = 8'h00;
    hp = 4'h0;
    forever begin
      @(negedge clk);
      total++;
      if (tt_cur !== m_tt) begin
        bad++; $display("FAIL tt_cur got=%h exp=%h t=%0t", tt_cur, m_tt, $time);
      end
      total++;
      if (beat_cnt !== m_beat) begin
        bad++; $display("FAIL beat_cnt got=%0d exp=%0d t=%0t", beat_cnt, m_beat, $time);
      end
      total++;
      if (rise_cnt !== m_rise) begin
        bad++; $display("FAIL rise_cnt got=%0d exp=%0d t=%0t", rise_cnt, m_rise, $time);
      end
      if (!rst_n) begin
        total++;
        if (bus.in_ready !== 1'b0) begin
          bad++; $display("FAIL in_ready_in_reset got=%b exp=0 t=%0t", bus.in_ready, $time);
        end
        exp_q.delete();
        m_tt = TT_RST; m_beat = '0; m_rise = '0; m_prev = 1'b0; hv = 1'b0;
      end else begin
        if (hv) begin
          total++;
          if (bus.out_valid !== 1'b1 || bus.out_data !== hd || bus.out_pop !== hp) begin
            bad++;
            $display("FAIL hold got v=%b d=%h p=%0d exp v=1 d=%h p=%0d t=%0t",
                     bus.out_valid, bus.out_data, bus.out_pop, hd, hp, $time);
          end
        end
        total++;
        if (bus.out_valid === 1'b1 && exp_q.size() == 0) begin
          bad++; $display("FAIL spurious_out got=valid exp=idle t=%0t", $time);
        end else if (bus.out_valid !== 1'b0 && bus.out_valid !== 1'b1) begin
          bad++; $display("FAIL out_valid_x got=%b exp=0/1 t=%0t", bus.out_valid, $time);
        end
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1 && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          total++;
          if (bus.out_data !== e) begin
            bad++; $display("FAIL out_data got=%h exp=%h t=%0t", bus.out_data, e, $time);
          end
          total++;
          if (bus.out_pop !== 4'($countones(e))) begin
            bad++; $display("FAIL out_pop got=%0d exp=%0d t=%0t", bus.out_pop, $countones(e), $time);
          end
          if (m_beat != 16'hFFFF) m_beat = m_beat + 16'd1;
          if (e[0] && !m_prev && m_rise != 16'hFFFF) m_rise = m_rise + 16'd1;
          m_prev = e[0];
        end
        if (cnt_clr) begin
          m_beat = '0; m_rise = '0;
        end
        hv = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b0);
        hd = bus.out_data;
        hp = bus.out_pop;
        if (bus.in_valid && bus.in_ready === 1'b1) exp_q.push_back(ref_lut(m_tt, bus.in_a, bus.in_b));
        if (cfg_we) m_tt = cfg_tt;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    total++;
    if (bus.out_valid !== 1'b0 || tt_cur !== TT_RST || beat_cnt !== 16'd0 || bus.out_data !== 8'h00) begin
      bad++; $display("FAIL reset_state got v=%b tt=%h bc=%0d d=%h exp v=0 tt=%h bc=0 d=00",
                      bus.out_valid, tt_cur, beat_cnt, bus.out_data, TT_RST);
    end
    rst_n = 1'b1;
    step();
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_a = 8'hF0; bus.in_b = 8'hCC;
    step();
    bus.in_valid = 1'b0;
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL latency_early got=%b exp=0", bus.out_valid);
    end
    step();
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h0C || bus.out_pop !== 4'd2) begin
      bad++; $display("FAIL first_beat got v=%b d=%h p=%0d exp v=1 d=0c p=2",
                      bus.out_valid, bus.out_data, bus.out_pop);
    end
    step();
    total++;
    if (beat_cnt !== 16'd1) begin
      bad++; $display("FAIL first_beat_cnt got=%0d exp=1", beat_cnt);
    end
  endtask

  task automatic test_cfg_same_cycle();
    bus.out_ready = 1'b1;
    cfg_we = 1'b1; cfg_tt = 4'b0110;
    bus.in_valid = 1'b1; bus.in_a = 8'hAA; bus.in_b = 8'h0F;
    step();
    cfg_we = 1'b0;
    step();
    bus.in_valid = 1'b0;
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h05) begin
      bad++; $display("FAIL old_table_beat got v=%b d=%h exp v=1 d=05", bus.out_valid, bus.out_data);
    end
    step();
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5 || bus.out_pop !== 4'd4) begin
      bad++; $display("FAIL new_table_beat got v=%b d=%h p=%0d exp v=1 d=a5 p=4",
                      bus.out_valid, bus.out_data, bus.out_pop);
    end
    step();
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1; bus.in_a = 8'($urandom); bus.in_b = 8'($urandom);
      #1;
      total++;
      if (bus.in_ready !== 1'b1) begin
        bad++; $display("FAIL b2b_in_ready cycle=%0d got=%b exp=1", i, bus.in_ready);
      end
      step();
    end
    bus.in_valid = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_backpressure();
    int acc;
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    bus.out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = 1'b1; bus.in_a = 8'($urandom); bus.in_b = 8'($urandom);
      #1;
      total++;
      if (bus.in_ready !== ((c < 2) ? 1'b1 : 1'b0)) begin
        bad++; $display("FAIL bp_in_ready cycle=%0d got=%b exp=%b", c, bus.in_ready, (c < 2));
      end
      if (bus.in_ready === 1'b1) acc++;
      step();
    end
    total++;
    if (acc != 2) begin
      bad++; $display("FAIL bp_accepted got=%0d exp=2", acc);
    end
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20 && acc < 4; c++) begin
      bus.in_valid = 1'b1; bus.in_a = 8'($urandom); bus.in_b = 8'($urandom);
      #1;
      if (bus.in_ready === 1'b1) acc++;
      step();
    end
    bus.in_valid = 1'b0;
    repeat (4) step();
    total++;
    if (beat_cnt !== 16'd4) begin
      bad++; $display("FAIL bp_beat_cnt got=%0d exp=4", beat_cnt);
    end
  endtask

  task automatic test_rise();
    logic [4:0] seq;
    logic       seen;
    seq = 5'b10110;  // delivered bit0 order: 0,1,1,0,1 (LSB first)
    bus.out_ready = 1'b1;
    cfg_we = 1'b1; cfg_tt = 4'b1100;  // out = a
    step();
    cfg_we = 1'b0; cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = 1'b1; bus.in_a = (8'($urandom) & 8'hFE) | {7'd0, seq[k]};
      bus.in_b = 8'($urandom);
      step();
    end
    bus.in_valid = 1'b0;
    repeat (3) step();
    total++;
    if (rise_cnt !== 16'd2 || beat_cnt !== 16'd5) begin
      bad++; $display("FAIL rise_seq got rc=%0d bc=%0d exp rc=2 bc=5", rise_cnt, beat_cnt);
    end
    for (int k = 0; k < 4; k++) begin
      bus.in_valid = 1'b1; bus.in_a = (8'($urandom) & 8'hFE) | {7'd0, seq[k]};
      bus.in_b = 8'($urandom);
      step();
    end
    bus.in_valid = 1'b0;
    repeat (3) step();
    bus.in_valid = 1'b1; bus.in_a = 8'h01; bus.in_b = 8'($urandom);
    step();
    bus.in_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (bus.out_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    total++;
    if (!seen) begin
      bad++; $display("FAIL rise_wait got=timeout exp=out_valid");
    end
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    total++;
    if (rise_cnt !== 16'd0 || beat_cnt !== 16'd0) begin
      bad++; $display("FAIL clr_with_hs got rc=%0d bc=%0d exp rc=0 bc=0", rise_cnt, beat_cnt);
    end
  endtask

  task automatic test_saturation();
    bus_s.out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bus_s.in_valid = 1'b1; bus_s.in_a = 8'($urandom); bus_s.in_b = 8'($urandom);
      step();
    end
    bus_s.in_valid = 1'b0;
    repeat (3) step();
    total++;
    if (beat_cnt_s !== 3'd7) begin
      bad++; $display("FAIL sat_beat_cnt got=%0d exp=7", beat_cnt_s);
    end
    for (int k = 0; k < 2; k++) begin
      bus_s.in_valid = 1'b1; bus_s.in_a = 8'($urandom); bus_s.in_b = 8'($urandom);
      step();
    end
    bus_s.in_valid = 1'b0;
    repeat (3) step();
    total++;
    if (beat_cnt_s !== 3'd7) begin
      bad++; $display("FAIL sat_hold got=%0d exp=7", beat_cnt_s);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_a      = 8'($urandom);
      bus.in_b      = 8'($urandom);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      cfg_we        = ($urandom_range(0, 7) == 0);
      cfg_tt        = 4'($urandom);
      cnt_clr       = ($urandom_range(0, 31) == 0);
      step();
    end
    bus.in_valid = 1'b0; cfg_we = 1'b0; cnt_clr = 1'b0; bus.out_ready = 1'b1;
    repeat (4) step();
  endtask

  task automatic test_reset_full();
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_a = 8'($urandom); bus.in_b = 8'($urandom);
    step();
    bus.in_valid = 1'b0;
    repeat (3) step();
    bus.out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      bus.in_valid = 1'b1; bus.in_a = 8'($urandom); bus.in_b = 8'($urandom);
      #1;
      if (bus.in_ready === 1'b0) break;
      step();
    end
    total++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
      bad++; $display("FAIL full_before_reset got rdy=%b v=%b exp rdy=0 v=1", bus.in_ready, bus.out_valid);
    end
    rst_n = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    step();
    rst_n = 1'b1;
    total++;
    if (bus.out_valid !== 1'b0 || beat_cnt !== 16'd0 || rise_cnt !== 16'd0 || tt_cur !== TT_RST) begin
      bad++; $display("FAIL reset_full got v=%b bc=%0d rc=%0d tt=%h exp v=0 bc=0 rc=0 tt=%h",
                      bus.out_valid, beat_cnt, rise_cnt, tt_cur, TT_RST);
    end
    repeat (3) step();
    total++;
    if (bus.out_valid !== 1'b0 || beat_cnt !== 16'd0) begin
      bad++; $display("FAIL reset_no_ghost got v=%b bc=%0d exp v=0 bc=0", bus.out_valid, beat_cnt);
    end
  endtask

  // ---------------- main ----------------
  initial begin
    total = 0; bad = 0;
    m_tt = TT_RST; m_beat = '0; m_rise = '0; m_prev = 1'b0;
    rst_n = 1'b0; cfg_we = 1'b0; cfg_tt = 4'h0; cnt_clr = 1'b0;
    bus.in_valid = 1'b0; bus.in_a = 8'h00; bus.in_b = 8'h00; bus.out_ready = 1'b0;
    bus_s.in_valid = 1'b0; bus_s.in_a = 8'h00; bus_s.in_b = 8'h00; bus_s.out_ready = 1'b0;
    fork
      monitor();
    join_none
    test_reset();
    test_cfg_same_cycle();
    test_back_to_back();
    test_backpressure();
    test_rise();
    test_saturation();
    test_random();
    test_reset_full();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
